// File: rtl/sprite_pkg.sv
// Shared defaults, channel state encoding and width helpers for the multi-sprite renderer.
package sprite_pkg;

    localparam int unsigned DEF_NUM_SPRITES = 4;
    localparam int unsigned DEF_SPR_W       = 8;
    localparam int unsigned DEF_SPR_H       = 16;
    localparam int unsigned DEF_COORD_W     = 9;
    localparam int unsigned DEF_POS_W       = 16;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_LOAD,
        WAIT_H,
        DRAW
    } ch_state_t;

    // Index width that never collapses to zero bits for single-entry ranges.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned DEF_IDX_W = clog2_min1(DEF_NUM_SPRITES);
    localparam int unsigned DEF_ROW_W = clog2_min1(DEF_SPR_H);

endpackage

// File: rtl/sprite_channel.sv
// One sprite channel: vertical trigger, row counter, one-row line buffer and
// MSB-first pixel shifter with optional horizontal mirror.
module sprite_channel
    import sprite_pkg::*;
#(
    parameter int unsigned SPR_W   = DEF_SPR_W,
    parameter int unsigned SPR_H   = DEF_SPR_H,
    parameter int unsigned COORD_W = DEF_COORD_W,
    parameter int unsigned POS_W   = DEF_POS_W
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [POS_W-1:0]             hpos,
    input  logic [POS_W-1:0]             vpos,
    input  logic [COORD_W-1:0]           x,
    input  logic [COORD_W-1:0]           y,
    input  logic                         en,
    input  logic                         mirror,
    input  logic                         slot,
    input  logic [SPR_W-1:0]             rom_bits,
    output logic [clog2_min1(SPR_H)-1:0] row,
    output logic                         gfx,
    output logic                         in_progress
);

    localparam int unsigned ROW_W = clog2_min1(SPR_H);
    localparam int unsigned CNT_W = $clog2(SPR_W + 1);

    ch_state_t          state, state_n;
    logic [ROW_W-1:0]   row_n;
    logic [SPR_W-1:0]   pix, pix_n, pix_rev, src;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic               gfx_n, in_progress_n;
    logic               vstart, hstart;

    assign vstart = (vpos == POS_W'(y)) && (hpos == '0);
    assign hstart = (hpos == POS_W'(x));

    always_comb begin
        pix_rev = '0;
        for (int unsigned b = 0; b < SPR_W; b++) pix_rev[b] = pix[SPR_W-1-b];
    end

    // Next-state logic; a dropped enable overrides everything.
    always_comb begin
        state_n       = state;
        row_n         = row;
        pix_n         = pix;
        cnt_n         = cnt;
        gfx_n         = 1'b0;
        in_progress_n = in_progress;
        src           = mirror ? pix_rev : pix;
        case (state)
            IDLE: begin
                if (vstart) begin
                    state_n       = WAIT_LOAD;
                    row_n         = '0;
                    in_progress_n = 1'b1;
                end
            end
            WAIT_LOAD: begin
                if (slot) begin
                    pix_n   = rom_bits;
                    state_n = WAIT_H;
                end
            end
            WAIT_H: begin
                if (hstart) begin
                    state_n = DRAW;
                    gfx_n   = src[SPR_W-1];
                    pix_n   = src << 1;
                    cnt_n   = CNT_W'(1);
                end
            end
            DRAW: begin
                if (cnt == CNT_W'(SPR_W)) begin
                    if (row == ROW_W'(SPR_H - 1)) begin
                        state_n       = IDLE;
                        in_progress_n = 1'b0;
                    end else begin
                        state_n = WAIT_LOAD;
                        row_n   = row + 1'b1;
                    end
                end else begin
                    gfx_n = pix[SPR_W-1];
                    pix_n = pix << 1;
                    cnt_n = cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
        if (!en) begin
            state_n       = IDLE;
            gfx_n         = 1'b0;
            in_progress_n = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            row         <= '0;
            pix         <= '0;
            cnt         <= '0;
            gfx         <= 1'b0;
            in_progress <= 1'b0;
        end else begin
            state       <= state_n;
            row         <= row_n;
            pix         <= pix_n;
            cnt         <= cnt_n;
            gfx         <= gfx_n;
            in_progress <= in_progress_n;
        end
    end

endmodule

// File: rtl/sprite_engine_multi.sv
// Multi-sprite renderer: per-sprite channels sharing one combinational ROM through
// a load-window sequencer, plus a per-frame sticky sprite-vs-sprite collision mask.
module sprite_engine_multi
    import sprite_pkg::*;
#(
    parameter int unsigned NUM_SPRITES = DEF_NUM_SPRITES,
    parameter int unsigned SPR_W       = DEF_SPR_W,
    parameter int unsigned SPR_H       = DEF_SPR_H,
    parameter int unsigned COORD_W     = DEF_COORD_W,
    parameter int unsigned POS_W       = DEF_POS_W
) (
    input  logic                                                  clk,
    input  logic                                                  reset,
    input  logic [POS_W-1:0]                                      hpos,
    input  logic [POS_W-1:0]                                      vpos,
    input  logic                                                  load,
    input  logic [NUM_SPRITES*COORD_W-1:0]                        spr_x,
    input  logic [NUM_SPRITES*COORD_W-1:0]                        spr_y,
    input  logic [NUM_SPRITES-1:0]                                spr_en,
    input  logic [NUM_SPRITES-1:0]                                spr_mirror,
    output logic [clog2_min1(NUM_SPRITES)+clog2_min1(SPR_H)-1:0]  rom_addr,
    input  logic [SPR_W-1:0]                                      rom_bits,
    output logic [NUM_SPRITES-1:0]                                gfx,
    output logic [NUM_SPRITES-1:0]                                in_progress,
    output logic [NUM_SPRITES-1:0]                                collide
);

    localparam int unsigned IDX_W = clog2_min1(NUM_SPRITES);
    localparam int unsigned ROW_W = clog2_min1(SPR_H);

    logic [IDX_W-1:0]       seq;
    logic                   seq_done;
    logic                   load_slot;
    logic [ROW_W-1:0]       row_arr [NUM_SPRITES];
    logic [NUM_SPRITES-1:0] hit;
    logic                   frame_start;

    // Slot sequencer: one ROM slot per channel per load window, last slot taken once.
    always_ff @(posedge clk) begin
        if (reset || !load) begin
            seq      <= '0;
            seq_done <= 1'b0;
        end else if (seq == IDX_W'(NUM_SPRITES - 1)) begin
            seq_done <= 1'b1;
        end else begin
            seq <= seq + 1'b1;
        end
    end

    assign load_slot = load && !seq_done;
    assign rom_addr  = {seq, row_arr[seq]};

    for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_ch
        sprite_channel #(
            .SPR_W   (SPR_W),
            .SPR_H   (SPR_H),
            .COORD_W (COORD_W),
            .POS_W   (POS_W)
        ) u_ch (
            .clk         (clk),
            .reset       (reset),
            .hpos        (hpos),
            .vpos        (vpos),
            .x           (spr_x[g*COORD_W +: COORD_W]),
            .y           (spr_y[g*COORD_W +: COORD_W]),
            .en          (spr_en[g]),
            .mirror      (spr_mirror[g]),
            .slot        (load_slot && (seq == IDX_W'(g))),
            .rom_bits    (rom_bits),
            .row         (row_arr[g]),
            .gfx         (gfx[g]),
            .in_progress (in_progress[g])
        );
    end

    always_comb begin
        hit = '0;
        for (int unsigned i = 0; i < NUM_SPRITES; i++)
            hit[i] = gfx[i] && ((gfx & ~(NUM_SPRITES'(1) << i)) != '0);
    end

    assign frame_start = (hpos == '0) && (vpos == '0);

    // Sticky per frame; a hit in the clearing cycle still sets its bit.
    always_ff @(posedge clk) begin
        if (reset) collide <= '0;
        else       collide <= (frame_start ? '0 : collide) | hit;
    end

endmodule
